// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Op encodings and the default-width stage payload.
package shift_pipe_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TAG_W   = 5;
  localparam int DEF_SHAMT_W = $clog2(DEF_WIDTH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0]   data;
    logic [DEF_SHAMT_W-1:0] shamt;
    logic [1:0]             op;
    logic [DEF_TAG_W-1:0]   tag;
    logic                   sign;
  } payload_t;

endpackage

// File: rtl/shift_pipe_if.sv
// Handshake bundle between a producer/consumer and the shifter.
// The master drives operations in and results out-ready.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;
  logic               busy;

  modport master (
    output flush, in_valid, in_data,
    output in_shamt, in_op, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_tag, out_zero, busy
  );

  modport slave (
    input  flush, in_valid, in_data,
    input  in_shamt, in_op, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_tag, out_zero, busy
  );

endinterface

// File: rtl/shift_pipe_stage.sv
// One shifter stage: conditional shift by DIST, then register.
// Holds its own valid bit and local advance logic.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int TAG_W   = DEF_TAG_W,
  parameter  int DIST    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_op,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_sign
);

  localparam int BIT = $clog2(DIST);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic [TAG_W-1:0]   tag;
    logic               sign;
  } stage_t;

  stage_t           nxt;
  stage_t           q;
  logic             vld;
  logic [WIDTH-1:0] sra_fill;

  // Sign bits that replace the vacated MSBs on an arithmetic shift
  assign sra_fill = in_sign ? ~({WIDTH{1'b1}} >> DIST) : '0;

  // Apply this stage's fixed shift when its shamt bit is set
  always_comb begin
    nxt.shamt = in_shamt;
    nxt.op    = in_op;
    nxt.tag   = in_tag;
    nxt.sign  = in_sign;
    nxt.data  = in_data;
    if (in_shamt[BIT]) begin
      unique case (in_op)
        OP_SLL: nxt.data = in_data << DIST;
        OP_SRL: nxt.data = in_data >> DIST;
        OP_SRA: nxt.data = (in_data >> DIST) | sra_fill;
        OP_ROL: nxt.data = (in_data << DIST)
                         | (in_data >> (WIDTH - DIST));
      endcase
    end
  end

  assign in_ready = !vld || out_ready;

  // Valid/payload register; payload only loads on a real transfer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (flush) begin
        vld <= 1'b0;
      end else if (in_ready) begin
        vld <= in_valid;
      end
      if (in_ready && in_valid && !flush) begin
        q <= nxt;
      end
    end
  end

  assign out_valid = vld;
  assign out_data  = q.data;
  assign out_shamt = q.shamt;
  assign out_op    = q.op;
  assign out_tag   = q.tag;
  assign out_sign  = q.sign;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined multi-mode barrel shifter, one stage per shamt bit.
// Stage 0 takes the largest shift; the last stage drives outputs.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic clock,
  input  logic reset,
  shift_pipe_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W:0]   vld;
  logic [SHAMT_W:0]   rdy;
  logic [SHAMT_W:0]   sgn;
  logic [WIDTH-1:0]   dat [SHAMT_W+1];
  logic [SHAMT_W-1:0] shm [SHAMT_W+1];
  logic [1:0]         op  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag [SHAMT_W+1];
  logic               unused_tail;

  assign vld[0] = bus.in_valid;
  assign dat[0] = bus.in_data;
  assign shm[0] = bus.in_shamt;
  assign op[0]  = bus.in_op;
  assign tag[0] = bus.in_tag;
  assign sgn[0] = bus.in_data[WIDTH-1];

  assign rdy[SHAMT_W] = bus.out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (bus.flush),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .in_shamt  (shm[k]),
      .in_op     (op[k]),
      .in_tag    (tag[k]),
      .in_sign   (sgn[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1]),
      .out_shamt (shm[k+1]),
      .out_op    (op[k+1]),
      .out_tag   (tag[k+1]),
      .out_sign  (sgn[k+1])
    );
  end

  assign bus.in_ready  = rdy[0] & ~bus.flush & ~reset;
  assign bus.out_valid = vld[SHAMT_W];
  assign bus.out_data  = dat[SHAMT_W];
  assign bus.out_tag   = tag[SHAMT_W];
  assign bus.out_zero  = (dat[SHAMT_W] == '0);
  assign bus.busy      = |vld[SHAMT_W:1];

  assign unused_tail = ^{shm[SHAMT_W], op[SHAMT_W], sgn[SHAMT_W]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and random checks of shift_pipe with a result scoreboard.
// Outputs are sampled 1ns after the falling edge.
module tb_shift_pipe;
  import shift_pipe_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int SW = 5;

  typedef struct {
    payload_t pl;
    int       cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           n_out, first_out, last_out;
  bit           chk_lat;
  logic [W-1:0] cur_exp;

  logic [W-1:0] bd [11] = '{
    32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001,
    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
    32'h0000_0001, 32'h8000_0000, 32'h1234_5678};
  int           bs [11] = '{31, 4, 4, 1, 0, 0, 0, 0, 1, 31, 8};
  logic [1:0]   bo [11] = '{
    OP_SLL, OP_SRL, OP_SRA, OP_ROL,
    OP_SLL, OP_SRL, OP_SRA, OP_ROL,
    OP_SRL, OP_SRA, OP_ROL};
  logic [W-1:0] be [11] = '{
    32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h0000_0003,
    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
    32'h0000_0000, 32'hFFFF_FFFF, 32'h3456_7812};

  function automatic logic [W-1:0] ref_shift(
    logic [W-1:0] d, int s, logic [1:0] o);
    logic [W-1:0] r;
    case (o)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = W'($signed(d) >>> s);
      default: r = (s == 0) ? d : ((d << s) | (d >> (W - s)));
    endcase
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic set_in(logic v, logic [W-1:0] d, int s,
                        logic [1:0] o, int t, logic [W-1:0] e);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shamt = SW'(s);
    bus.in_op    = o;
    bus.in_tag   = TW'(t);
    cur_exp      = e;
  endtask

  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      e.pl.data  = cur_exp;
      e.pl.shamt = bus.in_shamt;
      e.pl.op    = bus.in_op;
      e.pl.tag   = bus.in_tag;
      e.pl.sign  = bus.in_data[W-1];
      e.cyc      = cyc;
      sb.push_back(e);
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("out_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", bus.out_data, e.pl.data);
        chk("tag", bus.out_tag, e.pl.tag);
        chk("zero", bus.out_zero, e.pl.data == '0);
        if (chk_lat) chk("latency", cyc - e.cyc, SW);
      end
      n_out++;
      if (n_out == 1) first_out = cyc;
      last_out = cyc;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain(int maxc);
    bit a;
    bus.in_valid = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (sb.size() == 0) break;
      tick(a);
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    bit           acc;
    int           idx, guard, c0, s;
    logic [W-1:0] d;
    logic [1:0]   o;
    logic [W-1:0] pd [8];
    int           ps [8];
    logic [1:0]   po [8];

    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, 0, OP_SLL, 0, '0);
    chk_lat = 1'b1;
    n_out   = 0;

    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_zero", bus.out_zero, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      set_in(1'b1, bd[i], bs[i], bo[i], i, be[i]);
      tick(acc);
      chk("basic_accept", acc, 1);
    end
    drain(20);

    n_out = 0;
    c0    = cyc;
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      s = $urandom_range(0, W - 1);
      o = 2'($urandom_range(0, 3));
      set_in(1'b1, d, s, o, i, ref_shift(d, s, o));
      tick(acc);
      chk("stream_accept", acc, 1);
    end
    drain(20);
    chk("stream_first", first_out - c0, SW);
    chk("stream_count", n_out, 20);
    chk("stream_span", last_out - first_out, 19);

    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pd[i] = $urandom;
      ps[i] = $urandom_range(0, W - 1);
      po[i] = 2'($urandom_range(0, 3));
    end
    bus.out_ready = 1'b0;
    idx = 0;
    repeat (8) begin
      set_in(1'b1, pd[idx], ps[idx], po[idx], idx,
             ref_shift(pd[idx], ps[idx], po[idx]));
      tick(acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 5);
    #1;
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_busy", bus.busy, 1);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_hold0", bus.out_data, sb[0].pl.data);
    @(negedge clock);
    tick(acc);
    chk("bp_no_accept", acc, 0);
    chk("bp_hold1", bus.out_data, sb[0].pl.data);
    chk("bp_hold_tag", bus.out_tag, sb[0].pl.tag);
    bus.out_ready = 1'b1;
    guard = 0;
    while (idx < 8 && guard < 40) begin
      set_in(1'b1, pd[idx], ps[idx], po[idx], idx,
             ref_shift(pd[idx], ps[idx], po[idx]));
      tick(acc);
      if (acc) idx++;
      guard++;
    end
    chk("bp_rest", idx, 8);
    drain(30);
    chk_lat = 1'b1;

    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      set_in(1'b1, d, i + 3, OP_SRL, 10 + i, ref_shift(d, i + 3, OP_SRL));
      tick(acc);
    end
    bus.flush = 1'b1;
    set_in(1'b1, 32'h55, 0, OP_SLL, 9, 32'h55);
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick(acc);
    bus.flush = 1'b0;
    set_in(1'b0, '0, 0, OP_SLL, 0, '0);
    sb.delete();
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_busy", bus.busy, 0);
    @(negedge clock);
    set_in(1'b1, 32'h0F, 4, OP_SLL, 7, 32'hF0);
    tick(acc);
    chk("post_flush_accept", acc, 1);
    drain(10);

    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'hFFFF_0000 + i, 1, OP_ROL, 20 + i,
             ref_shift(32'hFFFF_0000 + i, 1, OP_ROL));
      tick(acc);
    end
    set_in(1'b0, '0, 0, OP_SLL, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_zero", bus.out_zero, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    @(negedge clock);
    sb.delete();
    reset = 1'b0;
    #1;
    chk("arst_rel_in_ready", bus.in_ready, 1);
    @(negedge clock);
    n_out = 0;
    repeat (12) tick(acc);
    chk("no_stale", n_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
